// File: rtl/delay_timer_scheduler_pkg.sv
// Shared types, default sizes and the length clipping rule for the delay timer scheduler.
package delay_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned DEF_NREQ    = 4;
    localparam int unsigned DEF_CBITS   = 16;
    localparam int unsigned DEF_MAX_LEN = 50000;

    // A zero-length request still occupies one counting cycle; oversize requests saturate.
    function automatic int unsigned clip_len(input int unsigned len, input int unsigned max_len);
        if (len == 0)
            return 1;
        else if (len > max_len)
            return max_len;
        else
            return len;
    endfunction

endpackage

// File: rtl/delay_timer_scheduler_arb.sv
// Combinational round-robin pick: first set request at or after i_ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_win,
    output logic [IW-1:0]   o_win_idx
);

    logic          w_found;
    logic [IW-1:0] w_j;

    always_comb begin
        o_win     = '0;
        o_win_idx = '0;
        w_found   = 1'b0;
        w_j       = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            w_j = IW'((int'(i_ptr) + k) % int'(NREQ));
            if (!w_found && i_req[w_j]) begin
                o_win[w_j] = 1'b1;
                o_win_idx  = w_j;
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/delay_timer_scheduler.sv
// One shared delay counter granted round-robin to NREQ requesters; pulses done to the owner.
//   state | meaning
//   IDLE  | no owner, arbitrate among pending requests
//   COUNT | owner holds the timer, cnt runs 1..L
//   DONE  | delay elapsed, done pulse, grant still held
module delay_timer_scheduler
    import delay_sched_pkg::*;
#(
    parameter int unsigned NREQ    = DEF_NREQ,
    parameter int unsigned CBITS   = DEF_CBITS,
    parameter int unsigned MAX_LEN = DEF_MAX_LEN,
    parameter int unsigned IW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       i_req,
    input  logic [NREQ*CBITS-1:0] i_len,
    output logic [NREQ-1:0]       o_gnt,
    output logic                  o_done,
    output logic [IW-1:0]         o_done_id,
    output logic                  o_busy,
    output logic                  o_sat
);

    if (MAX_LEN >= (64'd1 << CBITS)) begin : g_width_check
        $error("MAX_LEN does not fit in a CBITS-wide counter");
    end
    if (NREQ < 2) begin : g_nreq_check
        $error("NREQ must be at least 2");
    end

    state_t          r_state, w_state_n;
    logic [CBITS-1:0] r_cnt, w_cnt_n;
    logic [CBITS-1:0] r_len, w_len_n;
    logic [IW-1:0]    r_idx, w_idx_n;
    logic [IW-1:0]    r_ptr, w_ptr_n;
    logic [NREQ-1:0]  r_gnt, w_gnt_n;
    logic             r_sat, w_sat_n;

    logic [NREQ-1:0]  w_win;
    logic [IW-1:0]    w_win_idx;
    logic [CBITS-1:0] w_len_arr [NREQ];
    logic [CBITS-1:0] w_len_sel;
    logic [CBITS-1:0] w_clip_len;
    logic             w_clipped;
    logic [IW-1:0]    w_next_ptr;

    for (genvar g = 0; g < NREQ; g++) begin : g_len_unpack
        assign w_len_arr[g] = i_len[g*CBITS +: CBITS];
    end

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .i_req     (i_req),
        .i_ptr     (r_ptr),
        .o_win     (w_win),
        .o_win_idx (w_win_idx)
    );

    assign w_len_sel  = w_len_arr[w_win_idx];
    assign w_clip_len = CBITS'(clip_len(32'(w_len_sel), MAX_LEN));
    assign w_clipped  = (32'(w_len_sel) > MAX_LEN);
    assign w_next_ptr = (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + IW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_len   <= w_len_n;
            r_idx   <= w_idx_n;
            r_ptr   <= w_ptr_n;
            r_gnt   <= w_gnt_n;
            r_sat   <= w_sat_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_len_n   = r_len;
        w_idx_n   = r_idx;
        w_ptr_n   = r_ptr;
        w_gnt_n   = r_gnt;
        w_sat_n   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (|i_req) begin
                    w_state_n = COUNT;
                    w_cnt_n   = CBITS'(1);
                    w_len_n   = w_clip_len;
                    w_idx_n   = w_win_idx;
                    w_gnt_n   = w_win;
                    w_sat_n   = w_clipped;
                end
            end
            COUNT: begin
                // Withdrawal wins over completion, even on the last counting cycle.
                if (!i_req[r_idx]) begin
                    w_state_n = IDLE;
                    w_cnt_n   = '0;
                    w_gnt_n   = '0;
                    w_ptr_n   = w_next_ptr;
                end else if (r_cnt == r_len) begin
                    w_state_n = DONE;
                end else begin
                    w_cnt_n = r_cnt + CBITS'(1);
                end
            end
            DONE: begin
                w_state_n = IDLE;
                w_cnt_n   = '0;
                w_gnt_n   = '0;
                w_ptr_n   = w_next_ptr;
            end
            default: begin
                w_state_n = IDLE;
                w_gnt_n   = '0;
            end
        endcase
    end

    assign o_gnt     = r_gnt;
    assign o_done    = (r_state == DONE);
    assign o_done_id = o_done ? r_idx : '0;
    assign o_busy    = (r_state != IDLE);
    assign o_sat     = r_sat;

endmodule

// File: tb/tb_delay_timer_scheduler.sv
// Bench for delay_timer_scheduler: directed scenarios plus a randomized run against a cycle-window model.
module tb_delay_timer_scheduler;

    localparam int NREQ    = 4;
    localparam int CBITS   = 16;
    localparam int MAX_LEN = 50000;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*CBITS-1:0] len = '0;
    logic [NREQ-1:0]       gnt;
    logic                  done;
    logic [1:0]            done_id;
    logic                  busy;
    logic                  sat;

    int checks = 0;
    int errors = 0;

    delay_timer_scheduler #(.NREQ(NREQ), .CBITS(CBITS), .MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (req),
        .i_len     (len),
        .o_gnt     (gnt),
        .o_done    (done),
        .o_done_id (done_id),
        .o_busy    (busy),
        .o_sat     (sat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int i, input int v);
        len[i*CBITS +: CBITS] = CBITS'(v);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        len = '0;
        tick();
        tick();
        checks++;
        if ({gnt, done, done_id, busy, sat} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs got gnt=%b done=%b id=%0d busy=%b sat=%b exp all 0",
                     gnt, done, done_id, busy, sat);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [3:0] e_gnt;
        apply_reset();
        set_len(0, 5);
        req = 4'b0001;
        for (int k = 1; k <= 7; k++) begin
            tick();
            e_gnt = (k <= 6) ? 4'b0001 : 4'b0000;
            checks++;
            if (gnt !== e_gnt || done !== (k == 6) || busy !== (k <= 6)) begin
                errors++;
                $display("FAIL single_k%0d got gnt=%b done=%b busy=%b exp gnt=%b done=%b busy=%b",
                         k, gnt, done, busy, e_gnt, k == 6, k <= 6);
            end
            if (k == 6) begin
                checks++;
                if (done_id !== 2'd0) begin
                    errors++;
                    $display("FAIL single_done_id got %0d exp 0", done_id);
                end
                req = 4'b0000;
            end
        end
    endtask

    task automatic test_round_robin();
        int ph, own;
        logic [3:0] e_gnt;
        logic e_done;
        apply_reset();
        for (int i = 0; i < NREQ; i++) set_len(i, 2);
        req = 4'b1111;
        for (int c = 1; c <= 20; c++) begin
            tick();
            ph = (c - 1) % 4;
            own = ((c - 1) / 4) % 4;
            e_gnt = (ph == 3) ? 4'b0000 : 4'(1 << own);
            e_done = (ph == 2);
            checks++;
            if (gnt !== e_gnt || done !== e_done || (e_done && done_id !== 2'(own))) begin
                errors++;
                $display("FAIL rr_c%0d got gnt=%b done=%b id=%0d exp gnt=%b done=%b id=%0d",
                         c, gnt, done, done_id, e_gnt, e_done, own);
            end
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_boundaries();
        int done_at;
        apply_reset();
        set_len(2, 0);
        req = 4'b0100;
        tick();
        checks++;
        if (gnt !== 4'b0100 || done !== 1'b0 || sat !== 1'b0) begin
            errors++;
            $display("FAIL len0_t1 got gnt=%b done=%b sat=%b exp 0100 0 0", gnt, done, sat);
        end
        tick();
        checks++;
        if (done !== 1'b1 || done_id !== 2'd2) begin
            errors++;
            $display("FAIL len0_done got done=%b id=%0d exp 1 2", done, done_id);
        end
        req = '0;
        tick();

        apply_reset();
        set_len(2, 60000);
        req = 4'b0100;
        tick();
        checks++;
        if (sat !== 1'b1 || gnt !== 4'b0100) begin
            errors++;
            $display("FAIL sat_pulse got sat=%b gnt=%b exp 1 0100", sat, gnt);
        end
        tick();
        checks++;
        if (sat !== 1'b0) begin
            errors++;
            $display("FAIL sat_width got sat=%b exp 0", sat);
        end
        done_at = -1;
        if (done) done_at = 2;
        for (int k = 3; k <= 50010 && done_at < 0; k++) begin
            tick();
            if (done) begin
                done_at = k;
                checks++;
                if (done_id !== 2'd2) begin
                    errors++;
                    $display("FAIL sat_done_id got %0d exp 2", done_id);
                end
            end
        end
        checks++;
        if (done_at != MAX_LEN + 1) begin
            errors++;
            $display("FAIL sat_done_cycle got %0d exp %0d (-1 means timeout)", done_at, MAX_LEN + 1);
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_withdraw();
        apply_reset();
        set_len(1, 10);
        set_len(2, 3);
        req = 4'b0110;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (gnt !== 4'b0010 || done !== 1'b0) begin
                errors++;
                $display("FAIL wd_k%0d got gnt=%b done=%b exp 0010 0", k, gnt, done);
            end
        end
        req = 4'b0100;
        tick();
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL wd_cancel got gnt=%b busy=%b done=%b exp 0000 0 0", gnt, busy, done);
        end
        tick();
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL wd_next_grant got gnt=%b exp 0100", gnt);
        end
        req = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL wd_no_done got done=%b exp 0", done);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_len(1, 1);
        req = 4'b0010;
        tick();
        tick();
        req = '0;
        tick();
        set_len(2, 8);
        req = 4'b0100;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({gnt, done, done_id, busy, sat} !== 9'b0) begin
            errors++;
            $display("FAIL midrst_outputs got gnt=%b done=%b id=%0d busy=%b sat=%b exp all 0",
                     gnt, done, done_id, busy, sat);
        end
        rst = 1'b0;
        req = '0;
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++;
            if (done !== 1'b0 || gnt !== 4'b0000) begin
                errors++;
                $display("FAIL midrst_quiet got done=%b gnt=%b exp 0 0000", done, gnt);
            end
        end
        for (int i = 0; i < NREQ; i++) set_len(i, 3);
        req = 4'b1111;
        tick();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_ptr got gnt=%b exp 0001", gnt);
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_random();
        int  m_active, m_w, m_start, m_L, m_ptr, raw, n, idx;
        bit  m_clip, found;
        logic [3:0] e_gnt;
        logic e_done, e_sat;
        apply_reset();
        m_active = 0; m_w = 0; m_start = 0; m_L = 0; m_ptr = 0; m_clip = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if ($urandom_range(0, 39) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 5) == 0) begin
                    req[i] = 1'b1;
                end
                if ($urandom_range(0, 3) == 0) set_len(i, $urandom_range(0, 12));
            end
            if (m_active != 0 && cyc == m_start + m_L && $urandom_range(0, 1) == 0)
                req[m_w] = 1'b0;

            if (m_active != 0) begin
                if (cyc <= m_start + m_L - 1 && !req[m_w]) begin
                    m_active = 0;
                    m_ptr = (m_w + 1) % NREQ;
                end else if (cyc == m_start + m_L) begin
                    m_active = 0;
                    m_ptr = (m_w + 1) % NREQ;
                end
            end else if (req != '0) begin
                found = 0;
                for (int k = 0; k < NREQ; k++) begin
                    idx = (m_ptr + k) % NREQ;
                    if (!found && req[idx]) begin
                        m_w = idx;
                        found = 1;
                    end
                end
                raw = int'(len[m_w*CBITS +: CBITS]);
                m_L = (raw == 0) ? 1 : (raw > MAX_LEN) ? MAX_LEN : raw;
                m_clip = (raw > MAX_LEN);
                m_start = cyc + 1;
                m_active = 1;
            end

            tick();
            n = cyc + 1;
            e_gnt  = (m_active != 0) ? 4'(1 << m_w) : 4'b0000;
            e_done = (m_active != 0) && (n == m_start + m_L);
            e_sat  = (m_active != 0) && (n == m_start) && m_clip;
            checks++;
            if (gnt !== e_gnt || done !== e_done || busy !== (m_active != 0) || sat !== e_sat ||
                (e_done && done_id !== 2'(m_w))) begin
                errors++;
                $display("FAIL rand_c%0d got gnt=%b done=%b id=%0d busy=%b sat=%b exp gnt=%b done=%b id=%0d busy=%b sat=%b",
                         n, gnt, done, done_id, busy, sat, e_gnt, e_done, m_w, m_active != 0, e_sat);
            end
        end
        req = '0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_boundaries();
        test_withdraw();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
